// File: rtl/zero_det_pkg.sv
// Shared constants and elaboration-time helpers for the zero / leading-zero detector.
package zero_det_pkg;

    localparam int WIDTH_MIN      = 8;
    localparam int WIDTH_MAX      = 64;
    localparam int STAGES_MIN     = 1;
    localparam int STAGES_MAX     = 3;
    localparam int LANE_WIDTH_MIN = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit legal_params(input int width, input int lanes, input int stages);
        bit ok;
        ok = (width == 8) || (width == 16) || (width == 32) || (width == 64);
        ok = ok && (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
        ok = ok && (lanes >= 1) && ((lanes & (lanes - 1)) == 0);
        ok = ok && (lanes <= width / LANE_WIDTH_MIN);
        ok = ok && (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
        return ok;
    endfunction

    // Leading zeros of the low w bits of a (zero-extended) value.
    function automatic int count_lz(input logic [63:0] bits, input int w);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (i < w) begin
                if (bits[i]) begin
                    seen = 1'b1;
                end else if (!seen) begin
                    n++;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/zero_det_pipe_or_reduce.sv
// W-bit OR reduction; one instance per lane forms the first level of the zero-detect tree.
module or_reduce #(
    parameter int W = 8
) (
    input  logic [W-1:0] in_bits,
    output logic         out_or
);

    assign out_or = |in_bits;

endmodule

// File: rtl/zero_det_pipe.sv
// Pipelined zero / per-lane zero / leading-zero-count detector with valid/ready flow control.
module zero_det_pipe
    import zero_det_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_nonzero,
    output logic                    out_zero,
    output logic [LANES-1:0]        out_lane_zero,
    output logic [clog2(WIDTH):0]   out_lzc
);

    localparam int LW   = WIDTH / LANES;
    localparam int LZW  = clog2(WIDTH) + 1;
    localparam int LLZW = clog2(LW) + 1;

    if (!legal_params(WIDTH, LANES, PIPE_STAGES)) begin : g_bad_params
        $error("zero_det_pipe: illegal WIDTH/LANES/PIPE_STAGES combination");
    end

    logic                         advance;
    logic [LANES-1:0]             in_lane_nz;
    logic [LANES-1:0][LLZW-1:0]   in_lane_lzc;
    logic [LANES-1:0]             fin_lane_nz;
    logic [LANES-1:0][LLZW-1:0]   fin_lane_lzc;

    logic [PIPE_STAGES-1:0]       valid_q, valid_d;
    logic                         nonzero_q, nonzero_d;
    logic                         zero_q, zero_d;
    logic [LANES-1:0]             lane_zero_q, lane_zero_d;
    logic [LZW-1:0]               lzc_q, lzc_d;

    assign advance  = !valid_q[PIPE_STAGES-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        or_reduce #(.W(LW)) u_or_reduce (
            .in_bits (in_data[k*LW +: LW]),
            .out_or  (in_lane_nz[k])
        );
        assign in_lane_lzc[k] = LLZW'(count_lz(64'(in_data[k*LW +: LW]), LW));
    end

    // Lane results are the tree's intermediate nodes; extra stages carry them forward.
    if (PIPE_STAGES == 1) begin : g_single
        assign fin_lane_nz  = in_lane_nz;
        assign fin_lane_lzc = in_lane_lzc;
    end else begin : g_multi
        logic [LANES-1:0]           mid_nz_q  [PIPE_STAGES-1];
        logic [LANES-1:0]           mid_nz_d  [PIPE_STAGES-1];
        logic [LANES-1:0][LLZW-1:0] mid_lzc_q [PIPE_STAGES-1];
        logic [LANES-1:0][LLZW-1:0] mid_lzc_d [PIPE_STAGES-1];

        always_comb begin
            mid_nz_d  = mid_nz_q;
            mid_lzc_d = mid_lzc_q;
            if (advance) begin
                mid_nz_d[0]  = in_lane_nz;
                mid_lzc_d[0] = in_lane_lzc;
                for (int s = 1; s < PIPE_STAGES - 1; s++) begin
                    mid_nz_d[s]  = mid_nz_q[s-1];
                    mid_lzc_d[s] = mid_lzc_q[s-1];
                end
            end
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                for (int s = 0; s < PIPE_STAGES - 1; s++) begin
                    mid_nz_q[s]  <= '0;
                    mid_lzc_q[s] <= '0;
                end
            end else begin
                mid_nz_q  <= mid_nz_d;
                mid_lzc_q <= mid_lzc_d;
            end
        end

        assign fin_lane_nz  = mid_nz_q[PIPE_STAGES-2];
        assign fin_lane_lzc = mid_lzc_q[PIPE_STAGES-2];
    end

    always_comb begin
        valid_d = valid_q;
        if (advance) begin
            valid_d[0] = in_valid;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                valid_d[s] = valid_q[s-1];
            end
        end
    end

    // Leading zeros: whole empty lanes above the first non-empty lane, plus that lane's count.
    always_comb begin
        logic found;
        found       = 1'b0;
        nonzero_d   = nonzero_q;
        zero_d      = zero_q;
        lane_zero_d = lane_zero_q;
        lzc_d       = lzc_q;
        if (advance) begin
            nonzero_d   = |fin_lane_nz;
            zero_d      = ~|fin_lane_nz;
            lane_zero_d = ~fin_lane_nz;
            lzc_d       = '0;
            for (int k = LANES - 1; k >= 0; k--) begin
                if (!found) begin
                    lzc_d = lzc_d + (fin_lane_nz[k] ? LZW'(fin_lane_lzc[k]) : LZW'(LW));
                    found = fin_lane_nz[k];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q     <= '0;
            nonzero_q   <= 1'b0;
            zero_q      <= 1'b0;
            lane_zero_q <= '0;
            lzc_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            nonzero_q   <= nonzero_d;
            zero_q      <= zero_d;
            lane_zero_q <= lane_zero_d;
            lzc_q       <= lzc_d;
        end
    end

    assign out_valid     = valid_q[PIPE_STAGES-1];
    assign out_nonzero   = nonzero_q;
    assign out_zero      = zero_q;
    assign out_lane_zero = lane_zero_q;
    assign out_lzc       = lzc_q;

endmodule

// File: tb/tb_zero_det_pipe.sv
// Scoreboard bench for zero_det_pipe: directed corner cases plus a randomized flow-control sweep.
module tb_zero_det_pipe #(
    parameter int WIDTH       = 32,
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
);

    localparam int LZW = $clog2(WIDTH) + 1;
    localparam int LW  = WIDTH / LANES;

    logic               clock;
    logic               reset_n;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic               out_nonzero;
    logic               out_zero;
    logic [LANES-1:0]   out_lane_zero;
    logic [LZW-1:0]     out_lzc;

    zero_det_pipe #(
        .WIDTH       (WIDTH),
        .LANES       (LANES),
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_nonzero   (out_nonzero),
        .out_zero      (out_zero),
        .out_lane_zero (out_lane_zero),
        .out_lzc       (out_lzc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        longint           stamp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    longint    adv_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: straight from the definitions of the outputs.
    function automatic int ref_lzc(input logic [WIDTH-1:0] d);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (d[i]) return WIDTH - 1 - i;
        end
        return WIDTH;
    endfunction

    function automatic logic [LANES-1:0] ref_lane_zero(input logic [WIDTH-1:0] d);
        logic [LANES-1:0] r;
        logic [WIDTH-1:0] mask;
        mask = {WIDTH{1'b1}} >> (WIDTH - LW);
        for (int k = 0; k < LANES; k++) begin
            r[k] = (((d >> (k * LW)) & mask) == '0);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_operand();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       r = '0;
            1:       r = 64'(1) << $urandom_range(0, WIDTH - 1);
            2:       r = r >> $urandom_range(0, 63);
            default: ;
        endcase
        return r[WIDTH-1:0];
    endfunction

    bit               prev_rst  = 1'b0;
    bit               hold_armed = 1'b0;
    logic             held_nonzero, held_zero;
    logic [LANES-1:0] held_lane;
    logic [LZW-1:0]   held_lzc;

    // Monitor: retire/accept decisions are taken at the falling edge, which fixes what the next rising edge does.
    always @(negedge clock) begin
        sb_entry_t e;
        if (prev_rst) begin
            check("reset out_valid", 64'(out_valid), 64'(0));
            check("reset out_nonzero", 64'(out_nonzero), 64'(0));
            check("reset out_zero", 64'(out_zero), 64'(0));
            check("reset out_lane_zero", 64'(out_lane_zero), 64'(0));
            check("reset out_lzc", 64'(out_lzc), 64'(0));
            check("reset in_ready", 64'(in_ready), 64'(1));
        end
        if (hold_armed) begin
            check("stall out_valid", 64'(out_valid), 64'(1));
            check("stall out_nonzero", 64'(out_nonzero), 64'(held_nonzero));
            check("stall out_zero", 64'(out_zero), 64'(held_zero));
            check("stall out_lane_zero", 64'(out_lane_zero), 64'(held_lane));
            check("stall out_lzc", 64'(out_lzc), 64'(held_lzc));
        end
        hold_armed = 1'b0;
        if (!reset_n) begin
            sb_q.delete();
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected result: got out_lzc=%0d expected no result at %0t", out_lzc, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("out_lzc", 64'(out_lzc), 64'(ref_lzc(e.data)));
                    check("out_lane_zero", 64'(out_lane_zero), 64'(ref_lane_zero(e.data)));
                    check("out_zero", 64'(out_zero), 64'(e.data == '0));
                    check("out_nonzero", 64'(out_nonzero), 64'(e.data != '0));
                    check("latency", 64'(adv_cnt - e.stamp), 64'(PIPE_STAGES));
                end
            end
            if (out_valid && !out_ready) begin
                hold_armed   = 1'b1;
                held_nonzero = out_nonzero;
                held_zero    = out_zero;
                held_lane    = out_lane_zero;
                held_lzc     = out_lzc;
            end
            if (in_valid && in_ready) begin
                e.data  = in_data;
                e.stamp = adv_cnt;
                sb_q.push_back(e);
            end
            if (in_ready) adv_cnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic directed(input logic [WIDTH-1:0] d, input string name,
                            input logic exp_zero, input logic [LANES-1:0] exp_lane,
                            input int exp_lzc);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (PIPE_STAGES - 1) tick();
        check({name, " out_valid"}, 64'(out_valid), 64'(1));
        check({name, " out_zero"}, 64'(out_zero), 64'(exp_zero));
        check({name, " out_nonzero"}, 64'(out_nonzero), 64'(!exp_zero));
        check({name, " out_lane_zero"}, 64'(out_lane_zero), 64'(exp_lane));
        check({name, " out_lzc"}, 64'(out_lzc), 64'(exp_lzc));
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;

        directed('0, "all-zero", 1'b1, 4'b1111, 32);
        directed(WIDTH'(32'h0001_0000), "bit16", 1'b0, 4'b1011, 15);
        directed(WIDTH'(32'h8000_0000), "msb", 1'b0, 4'b0111, 0);

        // Back-to-back stream at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i <= 6 + PIPE_STAGES; i++) begin
            in_valid = (i < 8);
            in_data  = rand_operand();
            check("b2b in_ready", 64'(in_ready), 64'(1));
            tick();
            if (i + 1 - PIPE_STAGES >= 0 && i + 1 - PIPE_STAGES <= 7)
                check("b2b out_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        tick();

        // Fill the pipe against a stalled consumer, then release it.
        out_ready = 1'b0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            in_valid = 1'b1;
            in_data  = rand_operand();
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            in_data = rand_operand();
            check("stall in_ready", 64'(in_ready), 64'(0));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (PIPE_STAGES + 2) tick();
        check("stall drained", 64'(sb_q.size()), 64'(0));

        // Reset with two operands in flight; neither may ever be delivered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_operand();
        tick();
        in_data = rand_operand() | WIDTH'(1);
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n = 1'b1;
        check("flush out_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        repeat (PIPE_STAGES + 3) tick();

        // Randomized sweep with random flow control and occasional resets.
        for (int i = 0; i < 800; i++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = rand_operand();
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (PIPE_STAGES + 3) tick();
        check("final drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
